// File: rtl/timer_down.sv
// Minutes:seconds countdown timer with IDLE/RUN/PAUSE/DONE control.
// Registered outputs. Requests are single-cycle pulses, with priority stop > load > start.
module timer_down #(
   parameter int P_SEC_BIT = 6,
   parameter int P_MAX     = 59
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 one_sec_tick,
   input  logic                 load,
   input  logic [P_SEC_BIT-1:0] load_min,
   input  logic [P_SEC_BIT-1:0] load_sec,
   input  logic                 start,
   input  logic                 stop,
   output logic [P_SEC_BIT-1:0] min,
   output logic [P_SEC_BIT-1:0] sec,
   output logic                 running,
   output logic                 alarm,
   output logic                 done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_DONE
   } state_t;

   localparam logic [P_SEC_BIT-1:0] MAX_V = P_SEC_BIT'(P_MAX);
   localparam logic [P_SEC_BIT-1:0] ONE_V = P_SEC_BIT'(1);

   state_t               state_q, state_d;
   logic [P_SEC_BIT-1:0] min_q, min_d;
   logic [P_SEC_BIT-1:0] sec_q, sec_d;
   logic                 done_q, done_d;

   logic [P_SEC_BIT-1:0] load_min_c;
   logic [P_SEC_BIT-1:0] load_sec_c;
   logic                 tick_ok;
   logic                 time_zero;

   assign load_min_c = (load_min > MAX_V) ? MAX_V : load_min;
   assign load_sec_c = (load_sec > MAX_V) ? MAX_V : load_sec;
   assign tick_ok    = en & one_sec_tick;
   assign time_zero  = (min_q == '0) && (sec_q == '0);

   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sec_d   = sec_q;
      done_d  = 1'b0;

      if (stop) begin
         // Stop outranks everything, even where it has no effect of its own.
         case (state_q)
            ST_RUN:  state_d = ST_PAUSE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = state_q;
         endcase
      end else if (load && (state_q != ST_RUN)) begin
         min_d   = load_min_c;
         sec_d   = load_sec_c;
         state_d = ST_IDLE;
      end else if (start && ((state_q == ST_IDLE) || (state_q == ST_PAUSE))) begin
         // A tick on the start edge is swallowed; counting begins on the next one.
         if (!time_zero) begin
            state_d = ST_RUN;
         end
      end else if ((state_q == ST_RUN) && tick_ok) begin
         if (sec_q != '0) begin
            sec_d = sec_q - ONE_V;
            if ((min_q == '0) && (sec_q == ONE_V)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end else if (min_q != '0) begin
            min_d = min_q - ONE_V;
            sec_d = MAX_V;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         min_q   <= '0;
         sec_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         done_q  <= done_d;
      end
   end

   assign min     = min_q;
   assign sec     = sec_q;
   assign running = (state_q == ST_RUN);
   assign alarm   = (state_q == ST_DONE);
   assign done    = done_q;

endmodule
